// File: rtl/dlx_global_pkg.sv
// Shared DLX definitions: machine word type, encoding constants and the reset fetch address.
package dlx_global_pkg;

  typedef logic [31:0] dlx_word;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] SP_NOP     = 6'h00;

  // R-type encoding: opcode in [31:26], function code in [5:0].
  localparam dlx_word NOP_WORD = {OP_SPECIAL, 20'h0_0000, SP_NOP};
  localparam dlx_word RESET_PC = 32'h0000_0000;
  localparam dlx_word PC_STEP  = 32'd4;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic dlx_word word_align(input dlx_word addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/dlx_pipe_if.sv
// DLX instruction-fetch stage: PC register, instruction memory request and IF/ID pipe register.
// Update priority each cycle: dc_wait freeze, halt, stall, redirect, then normal fetch.
module dlx_pipe_if
  import dlx_global_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       dc_wait,
  input  logic       id_cond,
  input  dlx_word    id_npc,
  input  logic       id_halt,
  input  logic       id_illegal_instr,
  output logic       im_en,
  output dlx_word    im_addr,
  input  dlx_word    im_rdata,
  input  logic       im_ready,
  output dlx_word    if_id_npc,
  output dlx_word    if_id_ir,
  output logic       if_halted,
  output logic [1:0] if_state
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_FETCH  = 2'd1,
    S_ABORT  = 2'd2,
    S_HALTED = 2'd3
  } if_state_e;

  if_state_e state_q, state_d;
  dlx_word   pc_q, pc_d;
  dlx_word   ir_q, ir_d;
  dlx_word   npc_q, npc_d;
  dlx_word   pc_inc;
  logic      halt_req;

  assign pc_inc   = pc_q + PC_STEP;
  assign halt_req = id_halt | id_illegal_instr;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    npc_d   = npc_q;
    if (dc_wait || state_q == S_HALTED) begin
      // Full freeze; HALTED is left only through reset.
    end else if (halt_req && !stall) begin
      state_d = S_HALTED;
      ir_d    = NOP_WORD;
    end else if (stall) begin
      // pc and IF/ID hold; returned data is dropped, BOOT/ABORT still advance.
      if (state_q != S_FETCH) state_d = S_FETCH;
    end else if (id_cond) begin
      pc_d    = word_align(id_npc);
      ir_d    = NOP_WORD;
      state_d = (state_q == S_FETCH && !im_ready) ? S_ABORT : S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (im_ready) begin
            ir_d  = im_rdata;
            npc_d = pc_inc;
            pc_d  = pc_inc;
          end else begin
            ir_d = NOP_WORD;
          end
        end
        default: begin
          state_d = S_FETCH;
          ir_d    = NOP_WORD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_WORD;
      npc_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
    end
  end

  // Level handshake: im_en stays high with a stable im_addr until im_ready=1 is seen
  // at a clock edge; a redirect or halt withdraws the request instead.
  assign im_en     = (state_q == S_FETCH);
  assign im_addr   = pc_q;
  assign if_id_ir  = ir_q;
  assign if_id_npc = npc_q;
  assign if_halted = (state_q == S_HALTED);
  assign if_state  = state_q;

endmodule

// File: tb/tb_dlx_pipe_if.sv
// Directed bench for dlx_pipe_if: straight-line fetch, wait states, redirect, stall/freeze, halt, wrap, reset.
module tb_dlx_pipe_if;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [1:0]  BOOT   = 2'd0;
  localparam logic [1:0]  FETCH  = 2'd1;
  localparam logic [1:0]  ABORT  = 2'd2;
  localparam logic [1:0]  HALTED = 2'd3;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        dc_wait;
  logic        id_cond;
  logic [31:0] id_npc;
  logic        id_halt;
  logic        id_illegal_instr;
  logic        im_en;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        im_ready;
  logic [31:0] if_id_npc;
  logic [31:0] if_id_ir;
  logic        if_halted;
  logic [1:0]  if_state;

  int total;
  int bad;

  dlx_pipe_if dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .dc_wait          (dc_wait),
    .id_cond          (id_cond),
    .id_npc           (id_npc),
    .id_halt          (id_halt),
    .id_illegal_instr (id_illegal_instr),
    .im_en            (im_en),
    .im_addr          (im_addr),
    .im_rdata         (im_rdata),
    .im_ready         (im_ready),
    .if_id_npc        (if_id_npc),
    .if_id_ir         (if_id_ir),
    .if_halted        (if_halted),
    .if_state         (if_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] st, input logic en,
                           input logic [31:0] addr, input logic [31:0] ir,
                           input logic [31:0] npc, input logic hlt);
    check({tag, ".state"}, {30'd0, if_state}, {30'd0, st});
    check({tag, ".im_en"}, {31'd0, im_en}, {31'd0, en});
    check({tag, ".im_addr"}, im_addr, addr);
    check({tag, ".ir"}, if_id_ir, ir);
    check({tag, ".npc"}, if_id_npc, npc);
    check({tag, ".halted"}, {31'd0, if_halted}, {31'd0, hlt});
  endtask

  task automatic drive(input logic rdy, input logic [31:0] data, input logic st,
                       input logic dcw, input logic cond, input logic [31:0] npc,
                       input logic hlt, input logic ill);
    im_ready = rdy; im_rdata = data; stall = st; dc_wait = dcw;
    id_cond = cond; id_npc = npc; id_halt = hlt; id_illegal_instr = ill;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    check_out("reset", BOOT, 1'b0, 32'h0, NOP, 32'h0, 1'b0);
    #10 rst = 1'b1;
    tick();
    check_out("boot_exit", FETCH, 1'b1, 32'h0, NOP, 32'h0, 1'b0);

    // Straight-line fetch
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    check_out("line0", FETCH, 1'b1, 32'h4, 32'h11, 32'h4, 1'b0);
    im_rdata = 32'h22; tick();
    check_out("line1", FETCH, 1'b1, 32'h8, 32'h22, 32'h8, 1'b0);
    im_rdata = 32'h33; tick();
    check_out("line2", FETCH, 1'b1, 32'hC, 32'h33, 32'hC, 1'b0);
    im_rdata = 32'h44; tick();
    check_out("line3", FETCH, 1'b1, 32'h10, 32'h44, 32'h10, 1'b0);

    // Three wait states at 0x10
    im_ready = 1'b0; im_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("wait", FETCH, 1'b1, 32'h10, NOP, 32'h10, 1'b0);
    end
    drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    check_out("wait_done", FETCH, 1'b1, 32'h14, 32'h55, 32'h14, 1'b0);

    // Redirect during a pending fetch, low target bits ignored
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h203, 1'b0, 1'b0); tick();
    check_out("abort", ABORT, 1'b0, 32'h200, NOP, 32'h14, 1'b0);
    id_cond = 1'b0; tick();
    check_out("after_abort", FETCH, 1'b1, 32'h200, NOP, 32'h14, 1'b0);
    drive(1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    check_out("tgt_fetch", FETCH, 1'b1, 32'h204, 32'h66, 32'h204, 1'b0);

    // Stall ignores data and redirect, then dc_wait ignores redirect
    drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_out("stall", FETCH, 1'b1, 32'h204, 32'h66, 32'h204, 1'b0);
    end
    drive(1'b1, 32'h77, 1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_out("dc_wait", FETCH, 1'b1, 32'h204, 32'h66, 32'h204, 1'b0);
    end
    drive(1'b1, 32'h88, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    check_out("resume", FETCH, 1'b1, 32'h208, 32'h88, 32'h208, 1'b0);

    // Redirect with data ready: no abort, fetched word squashed
    drive(1'b1, 32'h99, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0); tick();
    check_out("redir_rdy", FETCH, 1'b1, 32'h40, NOP, 32'h208, 1'b0);

    // Halt at 0x40, then only reset leaves HALTED
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); tick();
    check_out("halt", HALTED, 1'b0, 32'h40, NOP, 32'h208, 1'b1);
    drive(1'b1, 32'hAA, 1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out("halted", HALTED, 1'b0, 32'h40, NOP, 32'h208, 1'b1);
    end
    #2 rst = 1'b0;
    #1 check_out("halt_rst", BOOT, 1'b0, 32'h0, NOP, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    tick();
    check_out("reboot", FETCH, 1'b1, 32'h0, NOP, 32'h0, 1'b0);

    // Wrap-around at the top of the address space
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0); tick();
    check_out("wrap_abort", ABORT, 1'b0, 32'hFFFF_FFFC, NOP, 32'h0, 1'b0);
    id_cond = 1'b0; tick();
    drive(1'b1, 32'hBB, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    check_out("wrap", FETCH, 1'b1, 32'h0, 32'hBB, 32'h0, 1'b0);
    im_rdata = 32'hCC; tick();
    check_out("post_wrap", FETCH, 1'b1, 32'h4, 32'hCC, 32'h4, 1'b0);

    // Illegal instruction is held off by stall, then halts
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1); tick();
    check_out("ill_stall", FETCH, 1'b1, 32'h4, 32'hCC, 32'h4, 1'b0);
    stall = 1'b0; tick();
    check_out("ill_halt", HALTED, 1'b0, 32'h4, NOP, 32'h4, 1'b1);

    // Reset during a pending fetch drops the request at once
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    tick();
    check_out("rst2_boot", FETCH, 1'b1, 32'h0, NOP, 32'h0, 1'b0);
    drive(1'b1, 32'hEE, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    im_ready = 1'b0;
    #2 rst = 1'b0;
    #1 check_out("rst_midfetch", BOOT, 1'b0, 32'h0, NOP, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
